clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog.sv | 108 ++++++++++
 tb/tb_clk_div_prog.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable clock divider with a glitch-free divisor reload at the period wrap.
// Optional duty-cycle register: define CLK_DIV_PROG_DUTY_EN to add duty_in.
module clk_div_prog #(
    parameter int WIDTH     = 16,
    parameter int RESET_DIV = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_in,
`ifdef CLK_DIV_PROG_DUTY_EN
    input  logic [WIDTH-1:0] duty_in,
`endif
    input  logic             div_load,
    output logic             div_pending,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_fall
);

    localparam logic [WIDTH-1:0] RST_A = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] RST_U = WIDTH'(RESET_DIV / 2);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

    logic [WIDTH-1:0] div_a, div_p, cnt;
    logic [WIDTH-1:0] a_n, p_n, c_n;
    logic             pend_v, v_n, clk_n;
    logic [WIDTH-1:0] duty_u, duty_p, u_n, up_n;
    logic [WIDTH-1:0] duty_src;

`ifdef CLK_DIV_PROG_DUTY_EN
    assign duty_src = duty_in;
    function automatic logic [WIDTH-1:0] high_of(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] u);
        return (u < a) ? u : a;
    endfunction
`else
    assign duty_src = '0;
    function automatic logic [WIDTH-1:0] high_of(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] u);
        return (a >> 1) | (u & '0);
    endfunction
`endif

    always_comb begin
        a_n   = div_a;
        p_n   = div_p;
        v_n   = pend_v;
        c_n   = cnt;
        clk_n = clk_out;
        u_n   = duty_u;
        up_n  = duty_p;
        if (div_a < TWO) begin
            // Stopped: a pending or fresh divisor is applied regardless of enable,
            // parking C at A-1 so the next enabled edge opens with a rising edge.
            c_n   = '0;
            clk_n = 1'b0;
            if (div_load || pend_v) begin
                a_n = div_load ? div_in : div_p;
                u_n = div_load ? duty_src : duty_p;
                v_n = 1'b0;
                if (a_n >= TWO) c_n = a_n - ONE;
            end
        end else if (enable && cnt == div_a - ONE) begin
            a_n   = div_load ? div_in : (pend_v ? div_p : div_a);
            u_n   = div_load ? duty_src : (pend_v ? duty_p : duty_u);
            v_n   = 1'b0;
            c_n   = '0;
            clk_n = (a_n >= TWO) && (c_n < high_of(a_n, u_n));
        end else begin
            if (div_load) begin
                p_n  = div_in;
                up_n = duty_src;
                v_n  = 1'b1;
            end
            if (enable) begin
                c_n   = cnt + ONE;
                clk_n = c_n < high_of(div_a, duty_u);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_a     <= RST_A;
            div_p     <= '0;
            pend_v    <= 1'b0;
            cnt       <= RST_A - ONE;
            duty_u    <= RST_U;
            duty_p    <= '0;
            clk_out   <= 1'b0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
        end else begin
            div_a     <= a_n;
            div_p     <= p_n;
            pend_v    <= v_n;
            cnt       <= c_n;
            duty_u    <= u_n;
            duty_p    <= up_n;
            clk_out   <= clk_n;
            tick_rise <= clk_n & ~clk_out;
            tick_fall <= ~clk_n & clk_out;
        end
    end

    assign div_pending = pend_v;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: stimulus queues expected {clk_out,rise,fall,pending}
// per edge, a monitor pops and compares after each edge (or on a reset-check strobe).
module tb_clk_div_prog;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] div_in = '0;
    logic        div_load = 1'b0;
    logic        div_pending, clk_out, tick_rise, tick_fall;
    logic        strobe = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          duty_ovr = -1;

    typedef struct packed {logic c; logic r; logic f; logic p;} exp_t;
    exp_t  q[$];
    string nq[$];

`ifdef CLK_DIV_PROG_DUTY_EN
    logic [15:0] duty_in = '0;
`endif

    clk_div_prog #(.WIDTH(16), .RESET_DIV(50)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .div_in(div_in),
`ifdef CLK_DIV_PROG_DUTY_EN
        .duty_in(duty_in),
`endif
        .div_load(div_load), .div_pending(div_pending), .clk_out(clk_out),
        .tick_rise(tick_rise), .tick_fall(tick_fall)
    );

    always #5 clk = ~clk;

    initial begin
        exp_t  e;
        exp_t  got;
        string nm;
        forever begin
            @(posedge clk or posedge strobe);
            #1;
            while (q.size() > 0) begin
                e   = q.pop_front();
                nm  = nq.pop_front();
                got = {clk_out, tick_rise, tick_fall, div_pending};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL %s: clk/rise/fall/pend got=%b want=%b at %0t", nm, got, e, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic step(input bit en, input bit ld, input int din, input exp_t e, input string nm);
        @(negedge clk);
        enable   = en;
        div_load = ld;
        div_in   = 16'(din);
`ifdef CLK_DIV_PROG_DUTY_EN
        duty_in  = (duty_ovr < 0) ? 16'(din / 2) : 16'(duty_ovr);
`endif
        q.push_back(e);
        nq.push_back(nm);
    endtask

    // One enabled period of hi high / lo low cycles, with up to two loads at edge indices.
    task automatic period(input int hi, input int lo, input int ld_i, input int din,
                          input int ld2_i, input int din2, input string nm);
        for (int i = 0; i < hi + lo; i++) begin
            exp_t e;
            e.c = (i < hi);
            e.r = (i == 0) && (hi > 0);
            e.f = (i == hi) && (hi > 0) && (lo > 0);
            e.p = (ld_i > 0) && (i >= ld_i);
            step(1'b1, (i == ld_i) || (i == ld2_i), (i == ld2_i) ? din2 : ((i == ld_i) ? din : 0), e, nm);
        end
    endtask

    task automatic reset_check(input string nm);
        q.push_back(exp_t'(4'b0000));
        nq.push_back(nm);
        strobe = 1'b1;
        #2;
        strobe = 1'b0;
    endtask

    initial begin
        #12;
        reset_check("reset_values");
        @(negedge clk);
        rst_n = 1'b1;

        period(25, 25, -1, 0, -1, 0, "div50_first_period");
        period(25, 25, 11, 5, -1, 0, "div50_load5_pending");
        for (int k = 0; k < 3; k++) period(2, 3, -1, 0, -1, 0, "div5_wave");

        period(2, 3, 1, 7, 3, 9, "two_loads_last_wins");
        for (int k = 0; k < 2; k++) period(4, 5, -1, 0, -1, 0, "div9_wave");

        period(4, 5, 2, 0, -1, 0, "load_zero");
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 0, exp_t'(4'b0000), "stopped_quiet");
        step(1'b0, 1'b1, 4, exp_t'(4'b0000), "stopped_load4_en_low");
        step(1'b0, 1'b0, 0, exp_t'(4'b0000), "stopped_parked");
        for (int k = 0; k < 2; k++) period(2, 2, -1, 0, -1, 0, "div4_wave");

        step(1'b1, 1'b0, 0, exp_t'(4'b1100), "hold_rise");
        for (int k = 0; k < 10; k++)
            step(1'b0, (k == 4), (k == 4) ? 6 : 0, exp_t'({3'b100, (k >= 4)}), "hold_frozen");
        step(1'b1, 1'b0, 0, exp_t'(4'b1001), "hold_resume_high");
        step(1'b1, 1'b0, 0, exp_t'(4'b0011), "hold_fall");
        step(1'b1, 1'b0, 0, exp_t'(4'b0001), "hold_low");
        step(1'b1, 1'b0, 0, exp_t'(4'b1100), "div6_rise");
        step(1'b1, 1'b1, 8, exp_t'(4'b1001), "div6_load8");
        @(negedge clk);
        enable   = 1'b0;
        div_load = 1'b0;
        #2;
        rst_n = 1'b0;
        reset_check("mid_period_reset");
        @(negedge clk);
        rst_n = 1'b1;
        period(25, 25, -1, 0, -1, 0, "after_reset_div50");

`ifdef CLK_DIV_PROG_DUTY_EN
        duty_ovr = 3;
        period(25, 25, 5, 10, -1, 0, "duty3_load");
        for (int k = 0; k < 2; k++) period(3, 7, -1, 0, -1, 0, "duty3_wave");
        duty_ovr = 12;
        period(3, 7, 4, 10, -1, 0, "duty12_load");
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 0, exp_t'({1'b1, (k == 0), 2'b00}), "duty12_const_high");
        duty_ovr = -1;
`endif

        @(negedge clk);
        enable   = 1'b0;
        div_load = 1'b0;
        @(posedge clk);
        #3;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
